// File: rtl/dco_dwa_if.sv
// Control and data bundle between the loop filter side and the DCO DWA driver.
// The master drives code and mode controls; the slave (the driver) returns the
// fine-bank enables, DWA pointer and coarse-band status.
interface dco_dwa_if #(
  parameter int CODE_SIZE = 5,
  parameter int UNITS     = 31,
  parameter int BAND_SIZE = 4
);
  logic                 enable;
  logic                 dwa_en;
  logic                 freeze;
  logic [CODE_SIZE-1:0] code_in;
  logic [UNITS-1:0]     unit_en;
  logic [CODE_SIZE-1:0] ptr_out;
  logic [BAND_SIZE-1:0] band_out;
  logic                 band_step;
  logic                 band_limit;

  modport master (
    output enable, dwa_en, freeze, code_in,
    input  unit_en, ptr_out, band_out, band_step, band_limit
  );

  modport slave (
    input  enable, dwa_en, freeze, code_in,
    output unit_en, ptr_out, band_out, band_step, band_limit
  );
endinterface

// File: rtl/dco_dwa_driver.sv
// DCO fine-bank driver: turns the delta-sigma fine code into a DWA-rotated
// thermometer vector and tracks the coarse band so the fine code stays centred.
module dco_dwa_driver #(
  parameter int CODE_SIZE  = 5,
  parameter int UNITS      = 31,
  parameter int BAND_SIZE  = 4,
  parameter int BAND_RESET = 8,
  parameter int HI_TH      = 28,
  parameter int LO_TH      = 3,
  parameter int DWELL      = 64,
  parameter int BLANK      = 256
) (
  input  logic     clk_ref,
  input  logic     rst,
  input  logic     VDD,
  input  logic     VSS,
  dco_dwa_if.slave io
);

  localparam int CNT_W = $clog2(DWELL);
  localparam int BLK_W = (BLANK > 1) ? $clog2(BLANK) : 1;

  localparam logic [CODE_SIZE:0]   UNITS_W    = (CODE_SIZE+1)'(UNITS);
  localparam logic [CODE_SIZE-1:0] HI_TH_W    = CODE_SIZE'(HI_TH);
  localparam logic [CODE_SIZE-1:0] LO_TH_W    = CODE_SIZE'(LO_TH);
  localparam logic [CNT_W-1:0]     DWELL_LAST = CNT_W'(DWELL - 1);
  localparam logic [BLK_W-1:0]     BLANK_LAST = BLK_W'(BLANK - 1);
  localparam logic [BAND_SIZE-1:0] BAND_MAX   = '1;
  localparam logic [BAND_SIZE-1:0] BAND_INIT  = BAND_SIZE'(BAND_RESET);
  localparam logic [UNITS-1:0]     ALL_ONES   = '1;

  typedef enum logic {
    ST_TRACK = 1'b0,
    ST_BLANK = 1'b1
  } state_t;

  // Supply ties carry no logic; fold them into a sink so they are not dangling.
  logic unused_supply;
  assign unused_supply = VDD ^ VSS;

  // DWA datapath
  logic [UNITS-1:0]     unit_en_q, unit_en_d;
  logic [CODE_SIZE-1:0] ptr_q, ptr_d;
  logic [UNITS-1:0]     therm, rotated;
  logic [CODE_SIZE:0]   ptr_sum;

  // Band tracker
  state_t               state_q, state_d;
  logic [CNT_W-1:0]     hi_q, hi_d, lo_q, lo_d;
  logic [BLK_W-1:0]     blank_q, blank_d;
  logic [BAND_SIZE-1:0] band_q, band_d;
  logic                 step_q, step_d;
  logic                 limit_q, limit_d;
  logic                 hit_hi, hit_lo;

  assign hit_hi = (io.code_in >= HI_TH_W);
  assign hit_lo = (io.code_in <= LO_TH_W);

  // Thermometer of the code, rotated to start at the DWA pointer, plus pointer advance.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    unit_en_d = unit_en_q;
    ptr_d     = ptr_q;
    therm     = ~(ALL_ONES << io.code_in);
    // The right shift supplies the bits that wrapped past the top element.
    rotated   = (therm << ptr_q) | (therm >> (UNITS_W - {1'b0, ptr_q}));
    ptr_sum   = {1'b0, ptr_q} + {1'b0, io.code_in};
    if (ptr_sum >= UNITS_W) begin
      ptr_sum = ptr_sum - UNITS_W;
    end
    if (io.enable) begin
      if (io.dwa_en) begin
        unit_en_d = rotated;
        ptr_d     = ptr_sum[CODE_SIZE-1:0];
      end else begin
        unit_en_d = therm;
      end
    end
  end

  // DWA registers: enables and pointer.
  always_ff @(posedge clk_ref) begin
    // NOTE: sequential state uses non-blocking assignment so all registers update together.
    if (rst) begin
      unit_en_q <= '0;
      ptr_q     <= '0;
    end else begin
      unit_en_q <= unit_en_d;
      ptr_q     <= ptr_d;
    end
  end

  // Band tracker next state: count rail dwell, step the band, then blank.
  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    blank_d = blank_q;
    band_d  = band_q;
    step_d  = 1'b0;
    limit_d = limit_q;
    if (io.enable) begin
      limit_d = 1'b0;
      case (state_q)
        ST_TRACK: begin
          if (io.freeze) begin
            hi_d = '0;
            lo_d = '0;
          end else begin
            hi_d = hit_hi ? hi_q + 1'b1 : '0;
            lo_d = hit_lo ? lo_q + 1'b1 : '0;
            if (hit_hi && hi_q == DWELL_LAST) begin
              if (band_q != BAND_MAX) begin
                band_d  = band_q + 1'b1;
                step_d  = 1'b1;
                hi_d    = '0;
                lo_d    = '0;
                blank_d = '0;
                state_d = ST_BLANK;
              end else begin
                // At the top rail: keep requesting, hold the count at the threshold.
                limit_d = 1'b1;
                hi_d    = DWELL_LAST;
              end
            end else if (hit_lo && lo_q == DWELL_LAST) begin
              if (band_q != '0) begin
                band_d  = band_q - 1'b1;
                step_d  = 1'b1;
                hi_d    = '0;
                lo_d    = '0;
                blank_d = '0;
                state_d = ST_BLANK;
              end else begin
                limit_d = 1'b1;
                lo_d    = DWELL_LAST;
              end
            end
          end
        end
        ST_BLANK: begin
          // Let the loop settle on the new band before tracking again.
          hi_d = '0;
          lo_d = '0;
          if (blank_q == BLANK_LAST) begin
            blank_d = '0;
            state_d = ST_TRACK;
          end else begin
            blank_d = blank_q + 1'b1;
          end
        end
        default: state_d = ST_TRACK;
      endcase
    end
  end

  // Band tracker registers.
  always_ff @(posedge clk_ref) begin
    if (rst) begin
      state_q <= ST_TRACK;
      hi_q    <= '0;
      lo_q    <= '0;
      blank_q <= '0;
      band_q  <= BAND_INIT;
      step_q  <= 1'b0;
      limit_q <= 1'b0;
    end else begin
      state_q <= state_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      blank_q <= blank_d;
      band_q  <= band_d;
      step_q  <= step_d;
      limit_q <= limit_d;
    end
  end

  assign io.unit_en    = unit_en_q;
  assign io.ptr_out    = ptr_q;
  assign io.band_out   = band_q;
  assign io.band_step  = step_q;
  assign io.band_limit = limit_q;

endmodule
